aes_decrypt_iter: RTL
=====================

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 The block SHALL have no parameters; it is fixed at AES-128 (Nk=4, Nr=10).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to decrypt data_in; sampled only in IDLE.
REQ-005 load_key  input  1  with start: 1 = expand key anew, 0 = reuse the stored schedule.
REQ-006 key  input  128  cipher key, sampled when start is accepted with a key expansion.
REQ-007 data_in  input  128  ciphertext, sampled when start is accepted.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  single-cycle pulse when data_out is valid.
REQ-010 data_out  output  128  plaintext, held until the next done or reset.
REQ-011 key_valid  output  1  high once a full schedule is stored.

Function
REQ-012 Byte order SHALL be FIPS-197 column-major: [127:120] is byte 0 (row 0, column 0) for state, key and outputs.
REQ-013 The FSM SHALL have states IDLE, KEYX, INIT, ROUND and FINAL.
REQ-014 IDLE: start=1 is accepted and data_in is latched; next state is KEYX if load_key=1 or key_valid=0, otherwise INIT.
REQ-015 KEYX: rk0 <= key at acceptance; each of 10 cycles computes rk[i] from rk[i-1] with the existing key_expansion at count=i (i=1..10); all 11 round keys are stored; key_valid is set on the last cycle; next state is INIT.
REQ-016 INIT (1 cycle): state <= ciphertext XOR rk10; round counter <= 9.
REQ-017 ROUND (9 cycles, r=9 down to 1): state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])); the counter decrements.
REQ-018 FINAL (1 cycle): data_out <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0); done=1; next state is IDLE.
REQ-019 Latency from the start-accept edge to the done=1 cycle SHALL be 21 cycles with expansion and 11 cycles with reuse.
REQ-020 start while busy=1 SHALL be ignored, with no effect on data, key or schedule.
REQ-021 start may be accepted in the cycle immediately after done (back-to-back); data_out stays stable until the following done.
REQ-022 load_key=0 with key_valid=0 SHALL force KEYX.
REQ-023 key and data_in changes after acceptance SHALL NOT affect the operation in flight.
REQ-024 InvSubBytes, InvShiftRows and InvMixColumns SHALL be combinational helper modules instantiated once each; there SHALL be one datapath round per cycle.

Reset
REQ-025 When reset=0 at a rising edge, the block SHALL go to IDLE and set busy=0, done=0, data_out=0, key_valid=0, the round keys to 0 and the counter to 0.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; the next start performs KEYX regardless of load_key.
REQ-027 start asserted during reset SHALL be ignored.

Verification
REQ-028 key=000102030405060708090a0b0c0d0e0f, data_in=69c4e0d86a7b0430d8cdb78070b4c55a, start=1, load_key=1 -> done on cycle 21, data_out=00112233445566778899aabbccddeeff, key_valid=1.
REQ-029 After REQ-028, start with load_key=0 and the same data_in while key=ffff...ff -> done on cycle 11 with the same plaintext.
REQ-030 key=2b7e151628aed2a6abf7158809cf4f3c, data_in=3925841d02dc09fbdc118597196a0b32, load_key=1 -> data_out=3243f6a8885a308d313198a2e0370734; then back-to-back start on the cycle after done with REQ-028 ciphertext and load_key=1 -> both results are correct and data_out is held between the two done pulses.
REQ-031 start pulsed at cycles 3, 8 and 15 of an operation, with data_in changing -> these starts are ignored, exactly one done occurs, and the result matches the originally latched data.
REQ-032 reset=0 at cycle 14 of an expansion-based operation -> no done, all outputs are 0 the next cycle; then start with load_key=0 -> KEYX still runs (done at 21) and the result is correct.
REQ-033 Randomized checks against a reference model: 1000 random key/plaintext pairs, encrypted by the model and decrypted by the block, with random load_key and idle gaps -> every plaintext matches and exactly one done occurs per accepted start.

Source files
------------

// File: rtl/aes_decrypt_iter_if.sv
// Request/response bundle for the iterative AES-128 decryptor.
// The master drives the request side, the slave returns status and result.
interface aes_decrypt_iter_if;
    logic         start;
    logic         load_key;
    logic [127:0] key;
    logic [127:0] data_in;
    logic         busy;
    logic         done;
    logic [127:0] data_out;
    logic         key_valid;

    modport master (
        output start, load_key, key, data_in,
        input  busy, done, data_out, key_valid
    );

    modport slave (
        input  start, load_key, key, data_in,
        output busy, done, data_out, key_valid
    );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one round per cycle, on-chip key schedule
// that can be kept and reused across blocks.
package aes_decrypt_iter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYX,
        S_INIT,
        S_ROUND,
        S_FINAL
    } state_t;

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the field inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3)
                 ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(logic [7:0] b);
        logic [7:0] y;
        y = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

module aes_inv_shift_rows (
    input  logic [127:0] i_d,
    output logic [127:0] o_q
);
    always_comb begin
        o_q = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o_q[127-8*(4*c+r) -: 8] =
                    i_d[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
    end
endmodule

module aes_inv_sub_bytes
    import aes_decrypt_iter_pkg::*;
(
    input  logic [127:0] i_d,
    output logic [127:0] o_q
);
    always_comb begin
        o_q = '0;
        for (int i = 0; i < 16; i++) begin
            o_q[127-8*i -: 8] = inv_sbox(i_d[127-8*i -: 8]);
        end
    end
endmodule

module aes_inv_mix_columns
    import aes_decrypt_iter_pkg::*;
(
    input  logic [127:0] i_d,
    output logic [127:0] o_q
);
    always_comb begin
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        o_q = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = i_d[127-32*c -: 8];
            a1 = i_d[119-32*c -: 8];
            a2 = i_d[111-32*c -: 8];
            a3 = i_d[103-32*c -: 8];
            o_q[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                               ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o_q[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                               ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o_q[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                               ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o_q[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                               ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end
endmodule

module aes_key_expansion
    import aes_decrypt_iter_pkg::*;
(
    input  logic [127:0] i_rk,
    input  logic [3:0]   i_round,
    output logic [127:0] o_rk
);
    logic [7:0]  w_rcon;
    logic [31:0] w_w3;
    logic [31:0] w_t;
    logic [31:0] w_n0;
    logic [31:0] w_n1;
    logic [31:0] w_n2;
    logic [31:0] w_n3;

    always_comb begin
        case (i_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_w3 = i_rk[31:0];
    assign w_t  = {sbox(w_w3[23:16]), sbox(w_w3[15:8]),
                   sbox(w_w3[7:0]),   sbox(w_w3[31:24])}
                ^ {w_rcon, 24'h000000};
    assign w_n0 = i_rk[127:96] ^ w_t;
    assign w_n1 = i_rk[95:64]  ^ w_n0;
    assign w_n2 = i_rk[63:32]  ^ w_n1;
    assign w_n3 = w_w3         ^ w_n2;
    assign o_rk = {w_n0, w_n1, w_n2, w_n3};
endmodule

module aes_decrypt_iter
    import aes_decrypt_iter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    aes_decrypt_iter_if.slave  bus
);
    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_rk [0:10];
    logic [127:0] r_st;
    logic [127:0] r_dout;
    logic [3:0]   r_cnt;
    logic         r_kv;
    logic         r_done;

    logic         w_busy;
    logic         w_acc;
    logic         w_expand;
    logic [127:0] w_rk_sel;
    logic [127:0] w_rk_prev;
    logic [127:0] w_rk_nxt;
    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    assign w_expand  = bus.load_key | ~r_kv;
    assign w_rk_prev = r_rk[r_cnt - 4'd1];

    aes_key_expansion u_kx (
        .i_rk    (w_rk_prev),
        .i_round (r_cnt),
        .o_rk    (w_rk_nxt)
    );

    aes_inv_shift_rows u_isr (.i_d(r_st),  .o_q(w_isr));
    aes_inv_sub_bytes  u_isb (.i_d(w_isr), .o_q(w_isb));
    assign w_ark = w_isb ^ w_rk_sel;
    aes_inv_mix_columns u_imc (.i_d(w_ark), .o_q(w_imc));

    always_ff @(posedge clk) begin
        if (!reset) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (bus.start)
                         w_fsm_nxt = w_expand ? S_KEYX : S_INIT;
            S_KEYX:  if (r_cnt == 4'd10) w_fsm_nxt = S_INIT;
            S_INIT:  w_fsm_nxt = S_ROUND;
            S_ROUND: if (r_cnt == 4'd1) w_fsm_nxt = S_FINAL;
            S_FINAL: w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // The counter reaches 0 on the last ROUND, so FINAL picks rk0 too.
    always_comb begin
        w_busy   = (r_fsm != S_IDLE);
        w_acc    = (r_fsm == S_IDLE) & bus.start;
        w_rk_sel = r_rk[r_cnt];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
            r_st   <= '0;
            r_dout <= '0;
            r_cnt  <= 4'd0;
            r_kv   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (w_acc) begin
                        r_st <= bus.data_in;
                        if (w_expand) begin
                            r_rk[0] <= bus.key;
                            r_cnt   <= 4'd1;
                            r_kv    <= 1'b0;
                        end
                    end
                end
                S_KEYX: begin
                    r_rk[r_cnt] <= w_rk_nxt;
                    r_cnt       <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) r_kv <= 1'b1;
                end
                S_INIT: begin
                    r_st  <= r_st ^ r_rk[10];
                    r_cnt <= 4'd9;
                end
                S_ROUND: begin
                    r_st  <= w_imc;
                    r_cnt <= r_cnt - 4'd1;
                end
                S_FINAL: begin
                    r_dout <= w_ark;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.data_out  = r_dout;
    assign bus.key_valid = r_kv;
endmodule
